dma_ch_sched: RTL and testbench

Per-burst scheduler for the SGDMA engine. It holds a transfer length per DMA channel and arbitrates round-robin between the active channels. Each transfer is cut into bursts of at most max_burst bytes, and the channel, length and direction of each burst are presented to the engine's burst interface. A burst is issued only once the PCIe transmit credits for that burst type are available. The block sits beside the WISHBONE DMA adapter, in the wb_clk_i domain.

---
 rtl/dma_sched_pkg.sv | 25 ++
 rtl/dma_rr_pick.sv | 30 +++
 rtl/dma_ch_sched.sv | 193 +++++++++++++++++++
 tb/tb_dma_ch_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// Shared definitions for the SGDMA burst scheduler: FSM states, credit unit,
// default burst size and the posted-data credit helper.
package dma_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_REQ    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UPDATE = 3'd5
  } sched_state_e;

  localparam int unsigned CREDIT_BYTES  = 16;
  localparam int unsigned CREDIT_SHIFT  = 4;
  localparam logic [15:0] DEFAULT_BURST = 16'd4096;

  // Posted data credits (16-byte units) needed for a burst, rounded up.
  function automatic logic [12:0] data_credits(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'(CREDIT_BYTES - 1);
    return 13'(sum >> CREDIT_SHIFT);
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin selector: first busy channel strictly after
// i_ptr, wrapping modulo NCH.
module dma_rr_pick
  import dma_sched_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic [NCH-1:0] i_busy,
  input  logic [1:0]     i_ptr,
  output logic [1:0]     o_idx,
  output logic           o_valid
);

  always_comb begin
    int unsigned c;
    o_idx   = '0;
    o_valid = 1'b0;
    c       = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      c = (32'(i_ptr) + k) % NCH;
      for (int unsigned j = 0; j < NCH; j++) begin
        if (!o_valid && (c == j) && i_busy[j]) begin
          o_idx   = 2'(j);
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dma_ch_sched.sv
// Per-burst round-robin DMA channel scheduler with PCIe credit gating.
// Optional watchdog on CHECK/WAIT enabled by defining DMA_SCHED_WATCHDOG_EN.
module dma_ch_sched
  import dma_sched_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned LEN_W = 24,
  parameter int unsigned WD_W  = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [NCH-1:0]       ch_start,
  input  logic [NCH*LEN_W-1:0] ch_len,
  input  logic [NCH-1:0]       ch_dir,
  input  logic [15:0]          max_burst,
  input  logic [8:0]           tx_ca_ph,
  input  logic [12:0]          tx_ca_pd,
  input  logic [8:0]           tx_ca_nph,
  output logic                 burst_req,
  output logic [1:0]           active_ch,
  output logic [15:0]          burst_len,
  output logic                 burst_dir,
  input  logic                 burst_ack,
  input  logic                 burst_done,
  output logic [NCH-1:0]       ch_busy,
  output logic [NCH-1:0]       ch_done,
  output logic [NCH-1:0]       ch_err,
  output logic [31:0]          debug
);

  if (NCH < 2 || NCH > 4 || WD_W < 2) begin : g_cfg_check
    $error("dma_ch_sched: unsupported NCH/WD_W configuration");
  end

  sched_state_e     r_state, w_next;
  logic [LEN_W-1:0] r_rem [NCH];
  logic [NCH-1:0]   r_dir, r_busy, r_done, r_err;
  logic [1:0]       r_rr_ptr, r_active_ch;
  logic [15:0]      r_burst_len;
  logic             r_burst_dir;

  logic [1:0]       w_grant;
  logic             w_grant_vld;
  logic [LEN_W-1:0] w_grant_rem, w_act_rem, w_rem_after;
  logic             w_grant_dir;
  logic [15:0]      w_eff_max, w_grant_len;
  logic             w_credit_ok, w_upd_last, w_wd_expire;
  logic [LEN_W-1:0] w_start_len [NCH];

  dma_rr_pick #(.NCH(NCH)) u_pick (
    .i_busy  (r_busy),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_grant),
    .o_valid (w_grant_vld)
  );

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      w_start_len[i] = {ch_len[i*LEN_W+3 +: LEN_W-3], 3'b000};
    end
  end

  always_comb begin
    w_eff_max = {max_burst[15:3], 3'b000};
    if (w_eff_max == '0 || w_eff_max > DEFAULT_BURST) w_eff_max = DEFAULT_BURST;
  end

  always_comb begin
    w_grant_rem = '0;
    w_grant_dir = 1'b0;
    w_act_rem   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_grant == 2'(i)) begin
        w_grant_rem = r_rem[i];
        w_grant_dir = r_dir[i];
      end
      if (r_active_ch == 2'(i)) w_act_rem = r_rem[i];
    end
  end

  always_comb begin
    if (32'(w_grant_rem) < 32'(w_eff_max)) w_grant_len = 16'(w_grant_rem);
    else                                   w_grant_len = w_eff_max;
  end

  assign w_rem_after = w_act_rem - LEN_W'(r_burst_len);
  assign w_upd_last  = (r_state == ST_UPDATE) && (w_rem_after == '0);
  assign w_credit_ok = r_burst_dir ? ((tx_ca_ph != '0) && (tx_ca_pd >= data_credits(r_burst_len)))
                                   : (tx_ca_nph != '0);

`ifdef DMA_SCHED_WATCHDOG_EN
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_run;

  assign w_wd_run    = (r_state == ST_CHECK) || (r_state == ST_WAIT);
  assign w_wd_expire = w_wd_run && (r_wd_cnt == '1);

  always_ff @(posedge wb_clk_i or negedge rstn) begin
    if (!rstn)                            r_wd_cnt <= '0;
    else if (!w_wd_run || w_next != r_state) r_wd_cnt <= '0;
    else                                  r_wd_cnt <= r_wd_cnt + 1'b1;
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (enable && |r_busy) w_next = ST_ARB;
      ST_ARB:    w_next = (enable && w_grant_vld) ? ST_CHECK : ST_IDLE;
      ST_CHECK:  if (!enable) w_next = ST_IDLE;
                 else if (w_credit_ok) w_next = ST_REQ;
      ST_REQ:    if (burst_ack) w_next = ST_WAIT;
      ST_WAIT:   if (burst_done) w_next = ST_UPDATE;
      ST_UPDATE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_wd_expire) w_next = ST_IDLE;
  end

  // ch_done merges registered pulses (zero-length start, watchdog) with the
  // UPDATE-cycle completion so the latter lands one cycle after burst_done.
  always_comb begin
    burst_req = (r_state == ST_REQ);
    ch_done   = r_done;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_upd_last && r_active_ch == 2'(i)) ch_done[i] = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NCH; i++) r_rem[i] <= '0;
      r_dir       <= '0;
      r_busy      <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_rr_ptr    <= 2'(NCH - 1);
      r_active_ch <= '0;
      r_burst_len <= '0;
      r_burst_dir <= 1'b0;
    end else begin
      r_done <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ch_start[i] && !r_busy[i]) begin
          r_rem[i] <= w_start_len[i];
          r_dir[i] <= ch_dir[i];
          r_err[i] <= 1'b0;
          if (w_start_len[i] == '0) r_done[i] <= 1'b1;
          else                      r_busy[i] <= 1'b1;
        end
      end
      if (r_state == ST_ARB && enable && w_grant_vld) begin
        r_active_ch <= w_grant;
        r_burst_len <= w_grant_len;
        r_burst_dir <= w_grant_dir;
      end
      if (r_state == ST_UPDATE) begin
        r_rr_ptr <= r_active_ch;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (r_active_ch == 2'(i)) begin
            r_rem[i] <= w_rem_after;
            if (w_rem_after == '0) r_busy[i] <= 1'b0;
          end
        end
      end
      if (w_wd_expire) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (r_active_ch == 2'(i)) begin
            r_err[i]  <= 1'b1;
            r_busy[i] <= 1'b0;
            r_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign active_ch = r_active_ch;
  assign burst_len = r_burst_len;
  assign burst_dir = r_burst_dir;
  assign ch_busy   = r_busy;
  assign ch_err    = r_err;
  assign debug     = 32'({r_state, r_rr_ptr, w_act_rem});

endmodule

// File: tb/tb_dma_ch_sched.sv
// Directed self-checking bench for dma_ch_sched (NCH=2, LEN_W=24).
module tb_dma_ch_sched;

`ifdef DMA_SCHED_WATCHDOG_EN
  localparam int unsigned WD     = 4;
  localparam int unsigned T4_IDLE = 10;
`else
  localparam int unsigned WD     = 16;
  localparam int unsigned T4_IDLE = 20;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [1:0]  ch_start;
  logic [47:0] ch_len;
  logic [1:0]  ch_dir;
  logic [15:0] max_burst;
  logic [8:0]  tx_ca_ph;
  logic [12:0] tx_ca_pd;
  logic [8:0]  tx_ca_nph;
  logic        burst_req;
  logic [1:0]  active_ch;
  logic [15:0] burst_len;
  logic        burst_dir;
  logic        burst_ack;
  logic        burst_done;
  logic [1:0]  ch_busy, ch_done, ch_err;
  logic [31:0] debug;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  dma_ch_sched #(.NCH(2), .LEN_W(24), .WD_W(WD)) dut (
    .wb_clk_i   (clk),
    .rstn       (rstn),
    .enable     (enable),
    .ch_start   (ch_start),
    .ch_len     (ch_len),
    .ch_dir     (ch_dir),
    .max_burst  (max_burst),
    .tx_ca_ph   (tx_ca_ph),
    .tx_ca_pd   (tx_ca_pd),
    .tx_ca_nph  (tx_ca_nph),
    .burst_req  (burst_req),
    .active_ch  (active_ch),
    .burst_len  (burst_len),
    .burst_dir  (burst_dir),
    .burst_ack  (burst_ack),
    .burst_done (burst_done),
    .ch_busy    (ch_busy),
    .ch_done    (ch_done),
    .ch_err     (ch_err),
    .debug      (debug)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic start(input logic [1:0] mask, input logic [23:0] l1, input logic [23:0] l0,
                       input logic [1:0] dir);
    ch_start = mask;
    ch_len   = {l1, l0};
    ch_dir   = dir;
    step();
    ch_start = '0;
  endtask

  task automatic serve_burst(input string tag, input logic [1:0] ech, input logic [15:0] elen,
                             input logic edir, input logic [1:0] edone);
    int unsigned n = 0;
    while (!burst_req && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 32'(burst_req), 32'd1);
    chk({tag, "_ch"},  32'(active_ch), 32'(ech));
    chk({tag, "_len"}, 32'(burst_len), 32'(elen));
    chk({tag, "_dir"}, 32'(burst_dir), 32'(edir));
    burst_ack = 1'b1;
    step();
    burst_ack = 1'b0;
    chk({tag, "_reqdrop"}, 32'(burst_req), 32'd0);
    step();
    burst_done = 1'b1;
    step();
    burst_done = 1'b0;
    chk({tag, "_chdone"}, 32'(ch_done), 32'(edone));
    step();
    chk({tag, "_donepulse"}, 32'(ch_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int unsigned seen;

    rstn = 1'b0; enable = 1'b1; ch_start = '0; ch_len = '0; ch_dir = '0;
    max_burst = 16'd128; tx_ca_ph = 9'd10; tx_ca_pd = 13'd100; tx_ca_nph = 9'd10;
    burst_ack = 1'b0; burst_done = 1'b0;
    step();
    chk("rst_req",   32'(burst_req), 32'd0);
    chk("rst_ch",    32'(active_ch), 32'd0);
    chk("rst_len",   32'(burst_len), 32'd0);
    chk("rst_dir",   32'(burst_dir), 32'd0);
    chk("rst_busy",  32'(ch_busy),   32'd0);
    chk("rst_done",  32'(ch_done),   32'd0);
    chk("rst_err",   32'(ch_err),    32'd0);
    chk("rst_debug", debug,          32'h0100_0000);
    rstn = 1'b1;
    step();

    // 1: single channel, two 128-byte writes, latency to burst_req
    start(2'b01, 24'd0, 24'd256, 2'b01);
    chk("t1_busy", 32'(ch_busy), 32'd1);
    chk("t1_req_c1", 32'(burst_req), 32'd0);
    step();
    chk("t1_req_c2", 32'(burst_req), 32'd0);
    step();
    chk("t1_req_c3", 32'(burst_req), 32'd0);
    chk("t1_dbg_check", debug, 32'h0900_0100);
    step();
    chk("t1_req_c4", 32'(burst_req), 32'd1);
    serve_burst("t1_b0", 2'd0, 16'd128, 1'b1, 2'b00);
    chk("t1_busy_mid", 32'(ch_busy), 32'd1);
    serve_burst("t1_b1", 2'd0, 16'd128, 1'b1, 2'b01);
    chk("t1_busy_end", 32'(ch_busy), 32'd0);

    // 2: two channels interleave round-robin
    do_reset();
    start(2'b11, 24'd256, 24'd256, 2'b01);
    chk("t2_busy", 32'(ch_busy), 32'd3);
    serve_burst("t2_b0", 2'd0, 16'd128, 1'b1, 2'b00);
    serve_burst("t2_b1", 2'd1, 16'd128, 1'b0, 2'b00);
    serve_burst("t2_b2", 2'd0, 16'd128, 1'b1, 2'b01);
    serve_burst("t2_b3", 2'd1, 16'd128, 1'b0, 2'b10);
    chk("t2_busy_end", 32'(ch_busy), 32'd0);

    // 3: posted data credit boundary, 7 short of 8 needed
    do_reset();
    tx_ca_pd = 13'd7;
    start(2'b01, 24'd0, 24'd128, 2'b01);
    for (int i = 0; i < 6; i++) step();
    d = debug;
    chk("t3_held_req", 32'(burst_req), 32'd0);
    chk("t3_state", 32'(d[28:26]), 32'd2);
    tx_ca_pd = 13'd8;
    step();
    chk("t3_req_now", 32'(burst_req), 32'd1);
    serve_burst("t3_b0", 2'd0, 16'd128, 1'b1, 2'b01);
    tx_ca_pd = 13'd100;

    // 4: read gated by non-posted header credit
    do_reset();
    tx_ca_nph = 9'd0;
    start(2'b10, 24'd64, 24'd0, 2'b00);
    seen = 0;
    for (int unsigned i = 0; i < T4_IDLE; i++) begin
      step();
      if (burst_req) seen++;
    end
    chk("t4_noreq", seen, 32'd0);
    tx_ca_nph = 9'd1;
    step();
    chk("t4_req_now", 32'(burst_req), 32'd1);
    serve_burst("t4_b0", 2'd1, 16'd64, 1'b0, 2'b10);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (burst_req) seen++;
    end
    chk("t4_single", seen, 32'd0);
    chk("t4_busy_end", 32'(ch_busy), 32'd0);
    tx_ca_nph = 9'd10;

    // 5: max_burst=0 means 4096, length truncated to 8-byte units; zero length
    do_reset();
    max_burst = 16'd0;
    start(2'b01, 24'd0, 24'd100, 2'b01);
    serve_burst("t5_b0", 2'd0, 16'd96, 1'b1, 2'b01);
    start(2'b10, 24'd0, 24'd0, 2'b00);
    chk("t5_zero_done", 32'(ch_done), 32'd2);
    chk("t5_zero_busy", 32'(ch_busy), 32'd0);
    step();
    chk("t5_zero_pulse", 32'(ch_done), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (burst_req) seen++;
    end
    chk("t5_zero_noreq", seen, 32'd0);
    max_burst = 16'd128;

    // enable low holds the scheduler in IDLE
    enable = 1'b0;
    start(2'b01, 24'd0, 24'd64, 2'b01);
    for (int i = 0; i < 6; i++) step();
    d = debug;
    chk("en_low_req", 32'(burst_req), 32'd0);
    chk("en_low_state", 32'(d[28:26]), 32'd0);
    enable = 1'b1;
    serve_burst("en_b0", 2'd0, 16'd64, 1'b1, 2'b01);

    // 6: asynchronous reset during WAIT
    do_reset();
    start(2'b01, 24'd0, 24'd256, 2'b01);
    for (int i = 0; i < 3; i++) step();
    chk("t6_req", 32'(burst_req), 32'd1);
    burst_ack = 1'b1;
    step();
    burst_ack = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(ch_busy),   32'd0);
    chk("t6_rst_len",   32'(burst_len), 32'd0);
    chk("t6_rst_dir",   32'(burst_dir), 32'd0);
    chk("t6_rst_debug", debug,          32'h0100_0000);
    step();
    rstn = 1'b1;
    step();

`ifdef DMA_SCHED_WATCHDOG_EN
    start(2'b01, 24'd0, 24'd64, 2'b01);
    for (int i = 0; i < 3; i++) step();
    chk("wd_req", 32'(burst_req), 32'd1);
    burst_ack = 1'b1;
    step();
    burst_ack = 1'b0;
    seen = 0;
    while (ch_err == 2'b00 && seen < 40) begin
      step();
      seen++;
    end
    chk("wd_cycles", seen, 32'd16);
    chk("wd_err", 32'(ch_err), 32'd1);
    chk("wd_done", 32'(ch_done), 32'd1);
    chk("wd_busy", 32'(ch_busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
